// File: rtl/mux8_frame_sequencer_pkg.sv
// Shared types and constants for the 8-way mux frame sequencer.
// Holds the word/select widths, the FSM state encoding and helpers that
// derive the first/last select positions from the LSB_FIRST setting.
package mux8_frame_sequencer_pkg;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_t;

    // Select value presented in the first cycle of a frame.
    function automatic logic [SEL_W-1:0] sel_first_f(input bit lsb_first);
        return lsb_first ? '0 : '1;
    endfunction

    // Select value at which a tick ends the data portion of the frame.
    function automatic logic [SEL_W-1:0] sel_last_f(input bit lsb_first);
        return lsb_first ? '1 : '0;
    endfunction

endpackage

// File: rtl/mux8_frame_sequencer_if.sv
// Parallel word handshake between a word source and the frame sequencer.
//   din       : word to serialize (source -> sequencer)
//   din_valid : din is presented   (source -> sequencer)
//   din_ready : sequencer can take a word (sequencer -> source)
interface mux8_frame_sequencer_if;
    import mux8_frame_sequencer_pkg::*;

    logic [WORD_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/mux8_frame_sequencer_sel_counter.sv
// Select-line counter for the frame sequencer.
// Synchronous active-high reset and clear force zero; load takes load_val;
// en steps by +1 (up=1) or -1 (up=0). Priority: rst > clr > load > en.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr, load, en : clear, load, step enable
//   up            : step direction
//   load_val      : value taken on load
//   sel           : registered select value
module mux8_frame_sequencer_sel_counter
    import mux8_frame_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [SEL_W-1:0] load_val,
    output logic [SEL_W-1:0] sel
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sel <= '0;
        end else if (load) begin
            sel <= load_val;
        end else if (en) begin
            sel <= up ? sel + SEL_W'(1) : sel - SEL_W'(1);
        end
    end

endmodule

// File: rtl/mux8_frame_sequencer.sv
// Upstream driver for the 8-way gate-level mux. Latches a parallel word from
// the handshake bus onto in0..in7 and walks the select lines s2..s0 across all
// eight positions, one per tick, so the mux output presents the word serially.
// Optional macro MUX8_SEQ_PARITY_EN adds a PARITY state after the last data
// bit and the parity_bit output (even parity of the held word).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : word handshake (din, din_valid, din_ready)
//   tick        : bit-step enable, ignored while idle
//   in0..in7    : held word bits to the mux data inputs
//   s0, s1, s2  : mux select lines, s0 is the LSB
//   busy        : frame in progress
//   bit_valid   : mux output carries a data bit this cycle
//   parity_bit  : parity of the held word while in PARITY (macro only)
//   done        : one-cycle pulse after the frame ends
module mux8_frame_sequencer
    import mux8_frame_sequencer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
)
(
    input  logic                         clk,
    input  logic                         rst,
    mux8_frame_sequencer_if.slave        bus,
    input  logic                         tick,
    output logic                         in0,
    output logic                         in1,
    output logic                         in2,
    output logic                         in3,
    output logic                         in4,
    output logic                         in5,
    output logic                         in6,
    output logic                         in7,
    output logic                         s0,
    output logic                         s1,
    output logic                         s2,
    output logic                         busy,
    output logic                         bit_valid,
`ifdef MUX8_SEQ_PARITY_EN
    output logic                         parity_bit,
`endif
    output logic                         done
);

    localparam logic [SEL_W-1:0] SEL_FIRST = sel_first_f(LSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_LAST  = sel_last_f(LSB_FIRST);

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] word_q;
    logic [SEL_W-1:0]  sel;
    logic              word_load;
    logic              sel_clr;
    logic              sel_load;
    logic              sel_en;
    logic              frame_end;
    logic              din_ready_q;
    logic              busy_q;
    logic              bit_valid_q;
    logic              done_q;
`ifdef MUX8_SEQ_PARITY_EN
    logic              parity_q;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; the end position is checked before stepping.
    always_comb begin
        state_d   = state_q;
        word_load = 1'b0;
        sel_clr   = 1'b0;
        sel_load  = 1'b0;
        sel_en    = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.din_valid) begin
                    word_load = 1'b1;
                    sel_load  = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sel == SEL_LAST) begin
`ifdef MUX8_SEQ_PARITY_EN
                        // Select holds on the last position through PARITY.
                        state_d   = PARITY;
`else
                        state_d   = IDLE;
                        sel_clr   = 1'b1;
                        frame_end = 1'b1;
`endif
                    end else begin
                        sel_en = 1'b1;
                    end
                end
            end
`ifdef MUX8_SEQ_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d   = IDLE;
                    sel_clr   = 1'b1;
                    frame_end = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                sel_clr = 1'b1;
            end
        endcase
    end

    // Word register and registered status outputs, computed from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q      <= '0;
            din_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef MUX8_SEQ_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            if (word_load) begin
                word_q <= bus.din;
            end
            din_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            bit_valid_q <= (state_d == SHIFT);
            done_q      <= frame_end;
`ifdef MUX8_SEQ_PARITY_EN
            parity_q    <= (state_d == PARITY) && (^word_q);
`endif
        end
    end

    mux8_frame_sequencer_sel_counter u_sel_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (sel_clr),
        .load     (sel_load),
        .en       (sel_en),
        .up       (LSB_FIRST),
        .load_val (SEL_FIRST),
        .sel      (sel)
    );

    assign bus.din_ready = din_ready_q;
    assign busy          = busy_q;
    assign bit_valid     = bit_valid_q;
    assign done          = done_q;
`ifdef MUX8_SEQ_PARITY_EN
    assign parity_bit    = parity_q;
`endif

    assign {s2, s1, s0} = sel;
    assign {in7, in6, in5, in4, in3, in2, in1, in0} = word_q;

endmodule
